maxpool_pad_writer: RTL and testbench

MAXPOOL_PAD_WRITER -- requirements
Module: maxpool_pad_writer

---
 rtl/maxpool_pad_writer.sv | 169 ++++++++++++++++
 tb/tb_maxpool_pad_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_pad_writer.sv
// 2x2/stride-2 max pooling of a channel-major pixel stream, written into a
// zero-padded next-layer feature-map RAM after clearing it once per frame.
module maxpool_pad_writer #(
  parameter int CHANNELS = 32,
  parameter int IN_W     = 28,
  parameter int IN_H     = 28,
  parameter int PAD      = 1,
  localparam int OUT_W   = IN_W / 2 + 2 * PAD,
  localparam int OUT_H   = IN_H / 2 + 2 * PAD,
  localparam int N       = CHANNELS * OUT_H * OUT_W,
  localparam int AW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    wr_data,
  output logic          wr_we,
  output logic [AW-1:0] wr_addr,
  output logic          overflow
);

  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int XW   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int LB_N = IN_W / 2;
  localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;

  localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IN_H - 1);
  localparam logic [XW-1:0] COL_LAST  = XW'(IN_W - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   ch;
  logic [RW-1:0]   row;
  logic [XW-1:0]   col;
  logic [7:0]      pair;
  logic [7:0]      lb_q;
  logic [7:0]      linebuf [LB_N];
  logic [7:0]      p;
  logic [7:0]      q;
  logic [LBW-1:0]  lb_idx;
  logic [AW-1:0]   pool_addr;
  logic            accept;
  logic            last_pix;

  assign busy     = (state == CLEAR) || (state == RUN);
  assign in_ready = (state == RUN);
  assign accept   = in_valid && (state == RUN);
  assign lb_idx   = LBW'(col >> 1);
  assign last_pix = (ch == CH_LAST) && (row == ROW_LAST) && (col == COL_LAST);

  assign p = (in_data > pair) ? in_data : pair;
  assign q = (lb_q > p) ? lb_q : p;

  // Computed at 32 bits and narrowed only once the final address is formed.
  assign pool_addr = AW'(32'(ch) * 32'(OUT_H * OUT_W)
                       + (32'(row >> 1) + 32'(PAD)) * 32'(OUT_W)
                       + 32'(col >> 1) + 32'(PAD));

  // The even-column pixel of an odd row prefetches the stored upper-row max,
  // so the odd-column pixel sees it in a register. That slot is only ever
  // written on even rows, so the prefetch cannot be stale.
  always_ff @(posedge clk) begin
    if (accept && !col[0])
      lb_q <= linebuf[lb_idx];
    if (accept && col[0] && !row[0])
      linebuf[lb_idx] <= p;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
      wr_we    <= 1'b0;
      wr_data  <= 8'd0;
      wr_addr  <= '0;
      ch       <= '0;
      row      <= '0;
      col      <= '0;
      pair     <= 8'd0;
    end else begin
      wr_we <= 1'b0;
      if (in_valid && state != RUN)
        overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            overflow <= 1'b0;
            ch       <= '0;
            row      <= '0;
            col      <= '0;
            pair     <= 8'd0;
            wr_we    <= 1'b1;
            wr_data  <= 8'd0;
            wr_addr  <= '0;
          end
        end

        CLEAR: begin
          if (wr_addr == ADDR_LAST) begin
            state <= RUN;
          end else begin
            wr_we   <= 1'b1;
            wr_addr <= wr_addr + AW'(1);
          end
        end

        RUN: begin
          if (accept) begin
            if (!col[0]) begin
              pair <= in_data;
            end else if (row[0]) begin
              wr_we   <= 1'b1;
              wr_data <= q;
              wr_addr <= pool_addr;
            end

            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row <= '0;
                ch  <= (ch == CH_LAST) ? '0 : ch + CW'(1);
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + XW'(1);
            end

            if (last_pix)
              state <= DONE;
          end
        end

        DONE: begin
          // done rises one cycle after entry, leaving the final pooled write
          // its own cycle before completion is signalled.
          if (start) begin
            state   <= CLEAR;
            done    <= 1'b0;
            ch      <= '0;
            row     <= '0;
            col     <= '0;
            pair    <= 8'd0;
            wr_we   <= 1'b1;
            wr_data <= 8'd0;
            wr_addr <= '0;
          end else begin
            done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_pad_writer.sv
// Scoreboard bench for maxpool_pad_writer: clear sweeps, pooled writes with
// cycle-exact timing, unsigned max, overflow, gapped input, restart, reset.
module tb_maxpool_pad_writer;

  localparam int CHANNELS = 2;
  localparam int IN_W     = 4;
  localparam int IN_H     = 4;
  localparam int PAD      = 1;
  localparam int OUT_W    = IN_W / 2 + 2 * PAD;
  localparam int OUT_H    = IN_H / 2 + 2 * PAD;
  localparam int N        = CHANNELS * OUT_H * OUT_W;
  localparam int AW       = $clog2(N);
  localparam int NPIX     = CHANNELS * IN_H * IN_W;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          busy;
  logic          done;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    wr_data;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic          overflow;

  maxpool_pad_writer #(
    .CHANNELS(CHANNELS), .IN_W(IN_W), .IN_H(IN_H), .PAD(PAD)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_data(wr_data), .wr_we(wr_we), .wr_addr(wr_addr), .overflow(overflow)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t  sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [7:0] frame [NPIX];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Every observed write is matched, in order, against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (wr_we === 1'b1) begin
      $display("write cycle=%0d addr=%0d data=%0d", cyc, wr_addr, wr_data);
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_start(input bit inject);
    int k;
    k = cyc;
    start = 1'b1;
    for (int i = 0; i < N; i++)
      sb.push_back('{addr: i, data: 0, cyc: k + 1 + i});
    @(negedge clk);
    start = 1'b0;
    chk("done_after_start", int'(done), 0);
    for (int i = 0; i < N; i++) begin
      chk("busy_clear", int'(busy), 1);
      chk("in_ready_clear", int'(in_ready), 0);
      if (inject && i == 3) begin
        in_valid = 1'b1;
        in_data  = 8'hAA;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("in_ready_after_clear", int'(in_ready), 1);
    chk("busy_run", int'(busy), 1);
    if (inject)
      chk("overflow_set", int'(overflow), 1);
  endtask

  task automatic stream_frame(input int n_pix, input int max_gap);
    int ch, r, c, base, q, a, g;
    for (int i = 0; i < n_pix; i++) begin
      if (max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        repeat (g) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      ch = i / (IN_W * IN_H);
      r  = (i / IN_W) % IN_H;
      c  = i % IN_W;
      chk("in_ready_run", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = frame[i];
      if ((r % 2) == 1 && (c % 2) == 1) begin
        base = ch * IN_W * IN_H;
        q = max2(max2(frame[base + (r - 1) * IN_W + c - 1], frame[base + (r - 1) * IN_W + c]),
                 max2(frame[base + r * IN_W + c - 1], frame[base + r * IN_W + c]));
        a = ch * OUT_H * OUT_W + (r / 2 + PAD) * OUT_W + (c / 2 + PAD);
        sb.push_back('{addr: a, data: q, cyc: cyc + 1});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (n_pix == NPIX) begin
      chk("in_ready_drop", int'(in_ready), 0);
      @(negedge clk);
      chk("done_set", int'(done), 1);
      chk("busy_idle", int'(busy), 0);
      chk("sb_empty", sb.size(), 0);
    end
  endtask

  task automatic ramp_frame();
    for (int i = 0; i < NPIX; i++) frame[i] = 8'(i);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_wr_we"}, int'(wr_we), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Clear and ramp pool.
    do_start(1'b0);
    ramp_frame();
    stream_frame(NPIX, 0);

    // Unsigned max windows, remainder random.
    for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom_range(0, 255));
    frame[0] = 8'd200;  frame[1] = 8'd255;  frame[4] = 8'd0;    frame[5] = 8'd128;
    frame[2] = 8'h80;   frame[3] = 8'h7F;   frame[6] = 8'h01;   frame[7] = 8'h00;
    do_start(1'b0);
    stream_frame(NPIX, 0);

    // Pixel offered during clear: dropped, sticky overflow, stream unaffected.
    do_start(1'b1);
    ramp_frame();
    stream_frame(NPIX, 0);
    chk("overflow_sticky", int'(overflow), 1);

    // Gapped input, then restart from DONE.
    stream_gap_and_restart();

    // Reset in the middle of a run.
    stream_frame(10, 0);
    rstn = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    chk("sb_empty_reset", sb.size(), 0);
    repeat (5) begin
      @(negedge clk);
      chk("no_we_in_reset", int'(wr_we), 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    do_start(1'b0);
    stream_frame(NPIX, 0);
    repeat (3) @(negedge clk);
    chk("sb_final_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic stream_gap_and_restart();
    do_start(1'b0);
    ramp_frame();
    stream_frame(NPIX, 3);
    do_start(1'b0);
  endtask

endmodule
